// File: rtl/noc_credit_tx.sv
// Credit-based NoC injection port: forwards upstream flits to a router local port one cycle
// after acceptance, tracking downstream buffer credits. Optional stall counter: NOC_TX_STALL_CNT_EN.
module noc_credit_tx #(
   parameter int DEST_WIDTH        = 4,
   parameter int FLIT_WIDTH        = 256,
   parameter int FLIT_BUFFER_DEPTH = 2,
   parameter int STALL_CNT_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [FLIT_WIDTH-1:0] in_data,
   input  logic [DEST_WIDTH-1:0] in_dest,
   input  logic                  in_last,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [FLIT_WIDTH-1:0] data_out,
   output logic [DEST_WIDTH-1:0] dest_out,
   output logic                  is_tail_out,
   output logic                  send_out,
   input  logic                  credit_in,
   output logic                  err_credit_ovf
`ifdef NOC_TX_STALL_CNT_EN
   ,
   output logic [STALL_CNT_WIDTH-1:0] stall_count
`endif
);

   localparam int CW = $clog2(FLIT_BUFFER_DEPTH + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(FLIT_BUFFER_DEPTH);

   typedef enum logic {S_HEAD, S_BODY} state_e;

   state_e                state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [DEST_WIDTH-1:0] dest_lock_q, dest_lock_d;
   logic                  send_q, send_d;
   logic [FLIT_WIDTH-1:0] data_q, data_d;
   logic [DEST_WIDTH-1:0] dest_q, dest_d;
   logic                  tail_q, tail_d;
   logic                  err_q, err_d;
   logic                  accept;

   // Ready depends only on the credit register, never on credit_in, so a
   // returned credit at zero opens the port one cycle later.
   assign in_ready = (cnt_q != '0) && !rst;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dest_lock_d = dest_lock_q;
      send_d      = 1'b0;
      data_d      = data_q;
      dest_d      = dest_q;
      tail_d      = tail_q;
      err_d       = err_q;

      if (accept) begin
         send_d = 1'b1;
         data_d = in_data;
         tail_d = in_last;
         case (state_q)
            S_HEAD: begin
               dest_d      = in_dest;
               dest_lock_d = in_dest;
               if (!in_last) state_d = S_BODY;
            end
            S_BODY: begin
               dest_d = dest_lock_q;
               if (in_last) state_d = S_HEAD;
            end
            default: state_d = S_HEAD;
         endcase
      end

      if (accept && !credit_in) begin
         cnt_d = cnt_q - CW'(1);
      end else if (!accept && credit_in) begin
         if (cnt_q == CNT_MAX) err_d = 1'b1;
         else                  cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_HEAD;
         cnt_q       <= CNT_MAX;
         dest_lock_q <= '0;
         send_q      <= 1'b0;
         data_q      <= '0;
         dest_q      <= '0;
         tail_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dest_lock_q <= dest_lock_d;
         send_q      <= send_d;
         data_q      <= data_d;
         dest_q      <= dest_d;
         tail_q      <= tail_d;
         err_q       <= err_d;
      end
   end

   assign send_out       = send_q;
   assign data_out       = data_q;
   assign dest_out       = dest_q;
   assign is_tail_out    = tail_q;
   assign err_credit_ovf = err_q;

`ifdef NOC_TX_STALL_CNT_EN
   logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

   always_comb begin
      stall_d = stall_q;
      if (in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + STALL_CNT_WIDTH'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) stall_q <= '0;
      else     stall_q <= stall_d;
   end

   assign stall_count = stall_q;
`endif

endmodule

// File: tb/tb_noc_credit_tx.sv
// Directed self-checking bench for noc_credit_tx (FLIT_BUFFER_DEPTH=2).
module tb_noc_credit_tx;
   localparam int DW = 4;
   localparam int FW = 256;
   localparam int SW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic [FW-1:0] in_data;
   logic [DW-1:0] in_dest;
   logic          in_last;
   logic          in_valid;
   logic          in_ready;
   logic [FW-1:0] data_out;
   logic [DW-1:0] dest_out;
   logic          is_tail_out;
   logic          send_out;
   logic          credit_in;
   logic          err_credit_ovf;
`ifdef NOC_TX_STALL_CNT_EN
   logic [SW-1:0] stall_count;
`endif

   int tests = 0;
   int fails = 0;

   noc_credit_tx #(
      .DEST_WIDTH(DW), .FLIT_WIDTH(FW), .FLIT_BUFFER_DEPTH(2), .STALL_CNT_WIDTH(SW)
   ) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_dest(in_dest), .in_last(in_last),
      .in_valid(in_valid), .in_ready(in_ready), .data_out(data_out), .dest_out(dest_out),
      .is_tail_out(is_tail_out), .send_out(send_out), .credit_in(credit_in),
      .err_credit_ovf(err_credit_ovf)
`ifdef NOC_TX_STALL_CNT_EN
      , .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [FW-1:0] d, input logic [DW-1:0] ds,
                        input logic l, input logic c);
      in_valid  = v;
      in_data   = d;
      in_dest   = ds;
      in_last   = l;
      credit_in = c;
   endtask

   task automatic chk_flit(input string name, input logic s, input logic [FW-1:0] d,
                           input logic [DW-1:0] ds, input logic t, input logic r);
      tests++;
      if (send_out !== s || data_out !== d || dest_out !== ds || is_tail_out !== t || in_ready !== r) begin
         fails++;
         $display("FAIL %s: got send=%b data=%0h dest=%0d tail=%b rdy=%b, want send=%b data=%0h dest=%0d tail=%b rdy=%b",
                  name, send_out, data_out, dest_out, is_tail_out, in_ready, s, d, ds, t, r);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, '0, '0, 1'b0, 1'b0);
      tick(); tick();
      chk_flit("reset_outputs", 1'b0, '0, '0, 1'b0, 1'b0);
      tests++;
      if (err_credit_ovf !== 1'b0) begin
         fails++; $display("FAIL reset_err: got %b want 0", err_credit_ovf);
      end
      rst = 1'b0;
      #1;
      tests++;
      if (in_ready !== 1'b1) begin
         fails++; $display("FAIL reset_release_ready: got %b want 1", in_ready);
      end
   endtask

   task automatic test_stall_packet();
      drive(1'b1, 256'hA0, 4'd5, 1'b0, 1'b0); tick();
      chk_flit("pkt_flit0", 1'b1, 256'hA0, 4'd5, 1'b0, 1'b1);
      drive(1'b1, 256'hA1, 4'd7, 1'b0, 1'b0); tick();
      chk_flit("pkt_flit1", 1'b1, 256'hA1, 4'd5, 1'b0, 1'b0);
      drive(1'b1, 256'hA2, 4'd7, 1'b1, 1'b0); tick();
      chk_flit("pkt_flit2_stall_a", 1'b0, 256'hA1, 4'd5, 1'b0, 1'b0);
      tick();
      chk_flit("pkt_flit2_stall_b", 1'b0, 256'hA1, 4'd5, 1'b0, 1'b0);
   endtask

   task automatic test_credit_release();
      credit_in = 1'b1;
      #1;
      tests++;
      if (in_ready !== 1'b0) begin
         fails++; $display("FAIL credit_same_cycle_ready: got %b want 0", in_ready);
      end
      tick();
      credit_in = 1'b0;
      chk_flit("credit_t_plus1", 1'b0, 256'hA1, 4'd5, 1'b0, 1'b1);
      tick();
      chk_flit("credit_t_plus2_tail", 1'b1, 256'hA2, 4'd5, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
      chk_flit("idle_after_tail", 1'b0, 256'hA2, 4'd5, 1'b1, 1'b1);
      tick();
      credit_in = 1'b0;
   endtask

   task automatic test_dest_lock_back_to_back();
      drive(1'b1, 256'hB0, 4'd3, 1'b0, 1'b0); tick();
      chk_flit("lock_head", 1'b1, 256'hB0, 4'd3, 1'b0, 1'b1);
      drive(1'b1, 256'hB1, 4'd9, 1'b0, 1'b1); tick();
      chk_flit("lock_body_b2b", 1'b1, 256'hB1, 4'd3, 1'b0, 1'b1);
      drive(1'b1, 256'hB2, 4'd9, 1'b1, 1'b1); tick();
      chk_flit("lock_tail_b2b", 1'b1, 256'hB2, 4'd3, 1'b1, 1'b1);
      drive(1'b1, 256'hB3, 4'd9, 1'b1, 1'b1); tick();
      chk_flit("next_head_dest9", 1'b1, 256'hB3, 4'd9, 1'b1, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b1); tick();
      credit_in = 1'b0;
   endtask

   task automatic test_credit_overflow();
      tests++;
      if (err_credit_ovf !== 1'b0) begin
         fails++; $display("FAIL ovf_before: got %b want 0", err_credit_ovf);
      end
      credit_in = 1'b1; tick();
      credit_in = 1'b0;
      tests++;
      if (err_credit_ovf !== 1'b1) begin
         fails++; $display("FAIL ovf_set: got %b want 1", err_credit_ovf);
      end
      drive(1'b1, 256'hC0, 4'd2, 1'b1, 1'b0); tick();
      chk_flit("ovf_sat_flit0", 1'b1, 256'hC0, 4'd2, 1'b1, 1'b1);
      drive(1'b1, 256'hC1, 4'd4, 1'b1, 1'b0); tick();
      chk_flit("ovf_sat_flit1", 1'b1, 256'hC1, 4'd4, 1'b1, 1'b0);
      drive(1'b0, '0, '0, 1'b0, 1'b0); tick(); tick();
      tests++;
      if (err_credit_ovf !== 1'b1) begin
         fails++; $display("FAIL ovf_sticky: got %b want 1", err_credit_ovf);
      end
      rst = 1'b1; credit_in = 1'b1; tick();
      rst = 1'b0; credit_in = 1'b0; #1;
      tests++;
      if (err_credit_ovf !== 1'b0 || in_ready !== 1'b1) begin
         fails++; $display("FAIL ovf_reset_clear: got err=%b rdy=%b want err=0 rdy=1", err_credit_ovf, in_ready);
      end
      tick();
      tests++;
      if (err_credit_ovf !== 1'b0) begin
         fails++; $display("FAIL rst_credit_ignored: got err=%b want 0", err_credit_ovf);
      end
   endtask

   task automatic test_reset_mid_packet();
      drive(1'b1, 256'hD0, 4'd4, 1'b0, 1'b0); tick();
      chk_flit("mid_head", 1'b1, 256'hD0, 4'd4, 1'b0, 1'b1);
      in_valid = 1'b0; rst = 1'b1; tick();
      rst = 1'b0;
      drive(1'b1, 256'hD1, 4'd6, 1'b1, 1'b0); tick();
      chk_flit("mid_new_head", 1'b1, 256'hD1, 4'd6, 1'b1, 1'b1);
      drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
      chk_flit("mid_idle_hold", 1'b0, 256'hD1, 4'd6, 1'b1, 1'b1);
   endtask

`ifdef NOC_TX_STALL_CNT_EN
   task automatic test_stall_count();
      rst = 1'b1; drive(1'b0, '0, '0, 1'b0, 1'b0); tick();
      rst = 1'b0;
      drive(1'b1, 256'hE0, 4'd1, 1'b1, 1'b0); tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      tests++;
      if (stall_count !== 32'd7) begin
         fails++; $display("FAIL stall_count_7: got %0d want 7", stall_count);
      end
      rst = 1'b1; in_valid = 1'b0; tick();
      rst = 1'b0;
      tests++;
      if (stall_count !== 32'd0) begin
         fails++; $display("FAIL stall_count_reset: got %0d want 0", stall_count);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stall_packet();
      test_credit_release();
      test_dest_lock_back_to_back();
      test_credit_overflow();
      test_reset_mid_packet();
`ifdef NOC_TX_STALL_CNT_EN
      test_stall_count();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
